// File: rtl/rx_interrupt_pkg.sv
// Shared types and constants for the multi-channel Rx interrupt moderator.
// Holds the FSM encoding, MSI vector width and channel-count limits.
package rx_interrupt_pkg;

  localparam int MSI_W  = 8;
  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_interrupt_moderator_rr_arbiter.sv
// Round-robin arbiter: search starts at the channel after the last grant.
// The pointer only moves when the caller accepts the grant.
module rr_arbiter
  import rx_interrupt_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_adv,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_j;

  // pick the first requester at or after the pointer, wrapping around
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_j = (int'(r_ptr) + k >= NUM_CH)
          ? IDX_W'(int'(r_ptr) + k - NUM_CH)
          : IDX_W'(int'(r_ptr) + k);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  // move the pointer past the channel just granted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_any) begin
      r_ptr <= (o_idx == IDX_W'(NUM_CH - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rx_interrupt_moderator.sv
// Coalesces per-channel Rx events and raises one MSI per eligible channel.
// Grants are round-robin; a global holdoff spaces consecutive interrupts.
module rx_interrupt_moderator
  import rx_interrupt_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int TMR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] evt,
  input  logic [NUM_CH-1:0] act_async,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_irq_en,
  input  logic              interrupts_enabled,
  input  logic [CNT_W-1:0]  evt_threshold,
  input  logic [TMR_W-1:0]  max_age,
  input  logic [TMR_W-1:0]  interrupt_period,
  output logic              cfg_interrupt_n,
  input  logic              cfg_interrupt_rdy_n,
  output logic [MSI_W-1:0]  cfg_interrupt_di,
  output logic [31:0]       irq_count
);

  localparam int IDX_W = idx_w(NUM_CH);

  logic [NUM_CH-1:0] r_sync1, r_sync2, r_sync3;
  logic [NUM_CH-1:0] r_ready;
  logic [NUM_CH-1:0] w_rise, w_ev, w_en;
  logic [NUM_CH-1:0] w_elig, w_clr, w_gnt;
  logic [CNT_W-1:0]  w_thr;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;

  state_t            r_state, w_state_nxt;
  logic              w_grant, w_ack;
  logic              r_int_n;
  logic [MSI_W-1:0]  r_di;
  logic [31:0]       r_irq_cnt;
  logic [TMR_W-1:0]  r_hcnt, r_period;

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_ev   = evt | w_rise;
  assign w_thr  = (evt_threshold == '0) ? CNT_W'(1) : evt_threshold;
  assign w_clr  = w_grant ? w_gnt : '0;

  // activity synchroniser, edge-detect history and buffer-ready register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_ready <= '0;
    end else begin
      r_sync1 <= act_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_ready <= ch_ready;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_age;

    assign w_en[g]   = ch_irq_en[g] & interrupts_enabled;
    assign w_elig[g] = r_pend & r_ready[g] & w_en[g]
                     & ((r_cnt >= w_thr) | (r_age >= max_age));

    // pending/count/age; a grant clears old content but keeps a new event
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pend <= 1'b0;
        r_cnt  <= '0;
        r_age  <= '0;
      end else if (!w_en[g]) begin
        r_pend <= 1'b0;
        r_cnt  <= '0;
        r_age  <= '0;
      end else if (w_clr[g]) begin
        r_pend <= w_ev[g];
        r_cnt  <= w_ev[g] ? CNT_W'(1) : '0;
        r_age  <= '0;
      end else begin
        if (w_ev[g]) begin
          r_pend <= 1'b1;
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        if (!r_pend) r_age <= '0;
        else if (r_age != '1) r_age <= r_age + 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (w_elig),
    .i_adv   (w_grant),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state plus grant/acknowledge strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!cfg_interrupt_rdy_n) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (r_hcnt == r_period) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // request/vector outputs, interrupt counter and holdoff timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_n   <= 1'b1;
      r_di      <= '0;
      r_irq_cnt <= '0;
      r_hcnt    <= '0;
      r_period  <= '0;
    end else begin
      if (w_grant) begin
        r_int_n <= 1'b0;
        r_di    <= MSI_W'(w_idx);
      end
      if (w_ack) begin
        r_int_n   <= 1'b1;
        r_irq_cnt <= r_irq_cnt + 32'd1;
        r_hcnt    <= '0;
        r_period  <= interrupt_period;
      end else if (r_state == ST_HOLDOFF) begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  assign cfg_interrupt_n  = r_int_n;
  assign cfg_interrupt_di = r_di;
  assign irq_count        = r_irq_cnt;

endmodule

// File: tb/tb_rx_interrupt_moderator.sv
// Bench for rx_interrupt_moderator: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rx_interrupt_moderator;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  evt = '0;
  logic [N-1:0]  act_async = '0;
  logic [N-1:0]  ch_ready = '1;
  logic [N-1:0]  ch_irq_en = '1;
  logic          interrupts_enabled = 1'b1;
  logic [15:0]   evt_threshold = 16'd1;
  logic [31:0]   max_age = 32'd1000;
  logic [31:0]   interrupt_period = 32'd10;
  logic          cfg_interrupt_rdy_n = 1'b1;
  logic          cfg_interrupt_n;
  logic [7:0]    cfg_interrupt_di;
  logic [31:0]   irq_count;

  int checks = 0;
  int errors = 0;
  int rdy_dly = 3;
  int wcnt = 0;

  rx_interrupt_moderator #(
    .NUM_CH (N),
    .CNT_W  (16),
    .TMR_W  (32)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .evt                 (evt),
    .act_async           (act_async),
    .ch_ready            (ch_ready),
    .ch_irq_en           (ch_irq_en),
    .interrupts_enabled  (interrupts_enabled),
    .evt_threshold       (evt_threshold),
    .max_age             (max_age),
    .interrupt_period    (interrupt_period),
    .cfg_interrupt_n     (cfg_interrupt_n),
    .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
    .cfg_interrupt_di    (cfg_interrupt_di),
    .irq_count           (irq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model: pending state per channel, one outstanding request,
  // and the earliest clock edge at which a new grant may happen
  bit          m_pend[N];
  int          m_cnt[N];
  longint      m_age[N];
  bit          m_rdy[N];
  bit [N-1:0]  h1, h2, h3;
  bit          m_req;
  int          m_vec;
  int          m_ptr;
  logic [31:0] m_count;
  longint      m_edge = 0;
  longint      m_free;
  int          thr, g, j;
  bit          en[N], ev[N], elig[N];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_cnt[i] = 0; m_age[i] = 0; m_rdy[i] = 0;
      end
      h1 = '0; h2 = '0; h3 = '0;
      m_req = 0; m_vec = 0; m_ptr = 0; m_count = 0; m_free = 0;
    end else begin
      thr = (evt_threshold == 16'd0) ? 1 : int'(evt_threshold);
      for (int i = 0; i < N; i++) begin
        en[i]   = ch_irq_en[i] && interrupts_enabled;
        ev[i]   = evt[i] || (h2[i] && !h3[i]);
        elig[i] = m_pend[i] && m_rdy[i] && en[i] &&
                  (m_cnt[i] >= thr || m_age[i] >= longint'(max_age));
      end
      g = -1;
      if (m_req) begin
        if (!cfg_interrupt_rdy_n) begin
          m_req   = 0;
          m_count = m_count + 1;
          m_free  = m_edge + longint'(interrupt_period) + 2;
        end
      end else if (m_edge >= m_free) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && elig[j]) g = j;
        end
        if (g >= 0) begin
          m_req = 1; m_vec = g; m_ptr = (g + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!en[i]) begin
          m_pend[i] = 0; m_cnt[i] = 0; m_age[i] = 0;
        end else if (i == g) begin
          m_pend[i] = ev[i]; m_cnt[i] = ev[i] ? 1 : 0; m_age[i] = 0;
        end else begin
          if (m_pend[i] && m_age[i] < 64'hFFFF_FFFF) m_age[i]++;
          if (ev[i]) begin
            m_pend[i] = 1;
            if (m_cnt[i] < 65535) m_cnt[i]++;
          end
        end
        m_rdy[i] = ch_ready[i];
      end
      h3 = h2; h2 = h1; h1 = act_async;
    end
    m_edge++;
  end

  // compare outputs against the model every cycle
  always @(negedge clk) begin
    chk("m_int_n", 32'(cfg_interrupt_n), 32'(!m_req));
    chk("m_vec", 32'(cfg_interrupt_di), 32'(m_vec));
    chk("m_count", irq_count, m_count);
  end

  // host side: acknowledge rdy_dly cycles after the request appears
  always @(negedge clk) begin
    #1;
    if (!cfg_interrupt_n) begin
      cfg_interrupt_rdy_n = (wcnt >= rdy_dly) ? 1'b0 : 1'b1;
      wcnt++;
    end else begin
      cfg_interrupt_rdy_n = 1'b1;
      wcnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    tick();
    evt[ch] = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_low(output int cyc);
    cyc = 0;
    while (cfg_interrupt_n && cyc < 2000) begin
      tick();
      cyc++;
    end
    checks++;
    if (cfg_interrupt_n) begin
      errors++;
      $display("FAIL wait_low timeout actual=1 required=0 t=%0t", $time);
    end
  endtask

  task automatic wait_high(output int cyc);
    cyc = 0;
    while (!cfg_interrupt_n && cyc < 2000) begin
      tick();
      cyc++;
    end
    checks++;
    if (!cfg_interrupt_n) begin
      errors++;
      $display("FAIL wait_high timeout actual=0 required=1 t=%0t", $time);
    end
  endtask

  int c, lows;
  logic [7:0] vecs[4];

  initial begin
    tick();
    chk("rst_int_n", 32'(cfg_interrupt_n), 32'd1);
    chk("rst_di", 32'(cfg_interrupt_di), 32'd0);
    chk("rst_count", irq_count, 32'd0);
    do_reset();

    // single event, threshold 1, period 10, ack after 3 cycles
    evt_threshold = 16'd1; interrupt_period = 32'd10; rdy_dly = 3;
    pulse(0);
    wait_low(c);
    chk("t1_lat", c, 1);
    chk("t1_vec", 32'(cfg_interrupt_di), 0);
    wait_high(c);
    chk("t1_len", c, 4);
    chk("t1_cnt", irq_count, 1);
    pulse(0);
    wait_low(c);
    chk("t1_hold", c, 11);
    wait_high(c);

    // event on channel 0 in its own grant cycle
    do_reset();
    evt[0] = 1'b1;
    tick();
    tick();
    evt[0] = 1'b0;
    wait_low(c);
    chk("t6_lat", c, 0);
    wait_high(c);
    wait_low(c);
    chk("t6_gap", c, 12);
    chk("t6_vec", 32'(cfg_interrupt_di), 0);
    wait_high(c);
    chk("t6_cnt", irq_count, 2);

    // age-based and count-based firing on channel 1
    do_reset();
    evt_threshold = 16'd4; max_age = 32'd1000; interrupt_period = 32'd0;
    pulse(1); pulse(1); pulse(1);
    wait_low(c);
    chk("t2_age_lat", c, 999);
    chk("t2_age_vec", 32'(cfg_interrupt_di), 1);
    wait_high(c);
    repeat (5) tick();
    pulse(1); pulse(1); pulse(1); pulse(1);
    wait_low(c);
    chk("t2_cnt_lat", c, 1);
    chk("t2_cnt_vec", 32'(cfg_interrupt_di), 1);
    wait_high(c);

    // both channels always eligible, period 0
    do_reset();
    evt_threshold = 16'd1; rdy_dly = 0;
    evt = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_low(c);
      vecs[k] = cfg_interrupt_di;
      wait_high(c);
    end
    evt = 2'b00;
    chk("t3_v0", 32'(vecs[0]), 0);
    chk("t3_v1", 32'(vecs[1]), 1);
    chk("t3_v2", 32'(vecs[2]), 0);
    chk("t3_v3", 32'(vecs[3]), 1);
    repeat (5) tick();

    // not-ready channel waits; disabled channel drops events
    do_reset();
    interrupt_period = 32'd2; rdy_dly = 1; ch_ready = 2'b10;
    pulse(0);
    lows = 0;
    repeat (20) begin
      tick();
      if (!cfg_interrupt_n) lows++;
    end
    chk("t4_blocked", lows, 0);
    ch_ready = 2'b11;
    wait_low(c);
    chk("t4_ready_lat", c, 2);
    chk("t4_vec", 32'(cfg_interrupt_di), 0);
    wait_high(c);
    repeat (5) tick();
    ch_irq_en[0] = 1'b0;
    pulse(0); pulse(0);
    repeat (3) tick();
    ch_irq_en[0] = 1'b1;
    lows = 0;
    repeat (20) begin
      tick();
      if (!cfg_interrupt_n) lows++;
    end
    chk("t4_dropped", lows, 0);

    // reset in the middle of a handshake
    do_reset();
    interrupt_period = 32'd10; rdy_dly = 0;
    pulse(0);
    wait_low(c);
    wait_high(c);
    chk("t5_cnt_pre", irq_count, 1);
    rdy_dly = 1000;
    repeat (15) tick();
    pulse(1);
    wait_low(c);
    tick();
    chk("t5_di_pre", 32'(cfg_interrupt_di), 1);
    reset_n = 1'b0;
    #1;
    chk("t5_int_n", 32'(cfg_interrupt_n), 1);
    chk("t5_di", 32'(cfg_interrupt_di), 0);
    chk("t5_cnt", irq_count, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle", 32'(cfg_interrupt_n), 1);
    chk("t5_cnt_post", irq_count, 0);

    // randomized traffic, checked by the model every cycle
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        evt_threshold    = 16'($urandom_range(0, 4));
        max_age          = 32'($urandom_range(3, 60));
        interrupt_period = 32'($urandom_range(0, 6));
        rdy_dly          = $urandom_range(0, 3);
        interrupts_enabled = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < N; i++) begin
          ch_irq_en[i] = ($urandom_range(0, 5) != 0);
          ch_ready[i]  = ($urandom_range(0, 3) != 0);
        end
      end
      for (int i = 0; i < N; i++) begin
        evt[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) act_async[i] = ~act_async[i];
        if ($urandom_range(0, 49) == 0) ch_ready[i] = ~ch_ready[i];
      end
      if (cyc == 1500) reset_n = 1'b0;
      if (cyc == 1502) reset_n = 1'b1;
      tick();
    end
    evt = '0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
